// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction fetch memory.
// Parity storage is enabled by defining IMEM_PARITY_EN.
package imem_pkg;

  localparam logic [9:0] HALT_WORD = 10'b1110000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Even parity: the returned bit makes the total count of ones even.
  // Zero-extend narrower words; extra zeros do not change parity.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Single write port, synchronous read RAM backing the instruction memory.
// Read data is registered and only changes on a read enable.
module imem_array #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 1024,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // No reset: contents and the read register survive rst_n.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: load port, one-cycle fetch with response hold.
// Define IMEM_PARITY_EN to store and check an even-parity bit per word.
module instr_fetch_mem
  import imem_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  output logic              busy
);

`ifdef IMEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int MEM_W = DATA_W + PAR_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [DATA_W-1:0] HALT_D  = DATA_W'(HALT_WORD);

  if (DEPTH > (1 << ADDR_W)) begin : g_depth_check
    $error("DEPTH must not exceed 2**ADDR_W");
  end

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              oor_q;
  logic              ld_in_range, req_in_range, accept;
  logic [MEM_W-1:0]  wr_word, rd_word;
  logic [DATA_W-1:0] rd_data;
  logic              par_err;

  assign ld_in_range  = {1'b0, ld_addr} < DEPTH_L;
  assign req_in_range = {1'b0, req_addr} < DEPTH_L;

  // A pending load always blocks acceptance so it cannot race a read.
  assign req_ready = !ld_en &&
                     (state_q == IDLE || (state_q == FETCH && rsp_ready));
  assign accept    = req_valid && req_ready;

`ifdef IMEM_PARITY_EN
  assign wr_word = {even_parity(64'(ld_data)), ld_data};
  assign rd_data = rd_word[DATA_W-1:0];
  assign par_err = ^rd_word;
`else
  assign wr_word = ld_data;
  assign rd_data = rd_word;
  assign par_err = 1'b0;
`endif

  imem_array #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (ld_en && ld_in_range),
    .waddr (ld_addr[IDX_W-1:0]),
    .wdata (wr_word),
    .re    (accept && req_in_range),
    .raddr (req_addr[IDX_W-1:0]),
    .rdata (rd_word)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = FETCH;
      end
      FETCH: begin
        if (!rsp_ready)  state_d = HOLD;
        else if (accept) state_d = FETCH;
        else             state_d = IDLE;
      end
      HOLD: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= req_addr;
        oor_q  <= !req_in_range;
      end
    end
  end

  // Response fields are gated by state so reset clears them immediately.
  assign rsp_valid = (state_q != IDLE);
  assign busy      = rsp_valid;
  assign rsp_addr  = rsp_valid ? addr_q : '0;
  assign rsp_err   = rsp_valid && (oor_q || par_err);
  assign rsp_data  = !rsp_valid ? '0 : (oor_q ? HALT_D : rd_data);

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed self-checking bench for instr_fetch_mem (DEPTH=28 instance).
module tb_instr_fetch_mem;

  localparam int DW = 10;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          rsp_err;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [DW-1:0] W0   = 10'b0010011110;
  localparam logic [DW-1:0] W1   = 10'b1100100010;
  localparam logic [DW-1:0] W3   = 10'h07B;
  localparam logic [DW-1:0] W5   = 10'h155;
  localparam logic [DW-1:0] W5B  = 10'h2AA;
  localparam logic [DW-1:0] W7   = 10'h1E5;
  localparam logic [DW-1:0] W27  = 10'h3C1;
  localparam logic [DW-1:0] JUNK = 10'h3FF;
  localparam logic [DW-1:0] HALT = 10'b1110000000;

  instr_fetch_mem #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (28)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    #1;
    chk("ld_blocks_ready", {31'd0, req_ready}, 32'd0);
    step();
    ld_en = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic e);
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    #1;
    $display("fetch %s addr=%0d data=%b err=%0b", tag, a, rsp_data, rsp_err);
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_data"},  {22'd0, rsp_data},  {22'd0, d});
    chk({tag, "_addr"},  {22'd0, rsp_addr},  {22'd0, a});
    chk({tag, "_err"},   {31'd0, rsp_err},   {31'd0, e});
    step();
  endtask

  initial begin
    rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;

    step();
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_err",   {31'd0, rsp_err},   32'd0);
    chk("rst_data",  {22'd0, rsp_data},  32'd0);
    chk("rst_addr",  {22'd0, rsp_addr},  32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    load(10'd0, W0);
    load(10'd1, W1);
    load(10'd3, W3);
    load(10'd5, W5);
    load(10'd27, W27);
    load(10'd28, JUNK);
    load(10'd32, JUNK);

    // Back-to-back fetches of addresses 0 and 1.
    req_valid = 1'b1; req_addr = 10'd0; rsp_ready = 1'b1;
    #1;
    chk("b2b_ready0", {31'd0, req_ready}, 32'd1);
    step();
    req_addr = 10'd1;
    #1;
    $display("b2b beat0 valid=%0b data=%b", rsp_valid, rsp_data);
    chk("b2b_valid0", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_data0",  {22'd0, rsp_data},  {22'd0, W0});
    chk("b2b_err0",   {31'd0, rsp_err},   32'd0);
    chk("b2b_ready1", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    #1;
    $display("b2b beat1 valid=%0b data=%b", rsp_valid, rsp_data);
    chk("b2b_valid1", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_data1",  {22'd0, rsp_data},  {22'd0, W1});
    chk("b2b_addr1",  {22'd0, rsp_addr},  32'd1);
    chk("b2b_err1",   {31'd0, rsp_err},   32'd0);
    step();
    chk("b2b_idle", {31'd0, busy}, 32'd0);

    // Stall address 5 for three cycles; a load to 5 must not disturb it.
    req_valid = 1'b1; req_addr = 10'd5; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    #1;
    chk("hold_c0_data",  {22'd0, rsp_data},  {22'd0, W5});
    chk("hold_c0_ready", {31'd0, req_ready}, 32'd0);
    step();
    chk("hold_c1_valid", {31'd0, rsp_valid}, 32'd1);
    chk("hold_c1_data",  {22'd0, rsp_data},  {22'd0, W5});
    chk("hold_c1_ready", {31'd0, req_ready}, 32'd0);
    ld_en = 1'b1; ld_addr = 10'd5; ld_data = W5B;
    step();
    ld_en = 1'b0;
    #1;
    $display("hold after load valid=%0b data=%b busy=%0b", rsp_valid, rsp_data, busy);
    chk("hold_c2_data",  {22'd0, rsp_data},  {22'd0, W5});
    chk("hold_c2_addr",  {22'd0, rsp_addr},  32'd5);
    chk("hold_c2_busy",  {31'd0, busy},      32'd1);
    chk("hold_c2_ready", {31'd0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    #1;
    chk("hold_rel_valid", {31'd0, rsp_valid}, 32'd1);
    chk("hold_rel_ready", {31'd0, req_ready}, 32'd0);
    step();
    chk("hold_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("hold_done_busy",  {31'd0, busy},      32'd0);
    fetch("refetch5", 10'd5, W5B, 1'b0);

    // Range boundaries.
    fetch("last27", 10'd27, W27, 1'b0);
    fetch("oor28", 10'd28, HALT, 1'b1);
    fetch("oor1023", 10'd1023, HALT, 1'b1);
    fetch("alias0", 10'd0, W0, 1'b0);

    // Load and fetch in the same cycle: load wins, fetch follows.
    ld_en = 1'b1; ld_addr = 10'd7; ld_data = W7;
    req_valid = 1'b1; req_addr = 10'd7; rsp_ready = 1'b1;
    #1;
    chk("coll_ready", {31'd0, req_ready}, 32'd0);
    step();
    ld_en = 1'b0;
    #1;
    chk("coll_not_busy", {31'd0, busy},      32'd0);
    chk("coll_ready2",   {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    #1;
    $display("collision fetch valid=%0b data=%b", rsp_valid, rsp_data);
    chk("coll_valid", {31'd0, rsp_valid}, 32'd1);
    chk("coll_data",  {22'd0, rsp_data},  {22'd0, W7});
    step();

    // Reset while holding a response.
    req_valid = 1'b1; req_addr = 10'd1; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    chk("rh_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    $display("reset in hold valid=%0b busy=%0b data=%b", rsp_valid, busy, rsp_data);
    chk("rh_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rh_busy",  {31'd0, busy},      32'd0);
    chk("rh_data",  {22'd0, rsp_data},  32'd0);
    step();
    rst_n = 1'b1; rsp_ready = 1'b1;
    step();
    chk("rh_no_late", {31'd0, rsp_valid}, 32'd0);
    fetch("post_rst1", 10'd1, W1, 1'b0);
    fetch("post_rst0", 10'd0, W0, 1'b0);

`ifdef IMEM_PARITY_EN
    fetch("par_ok3", 10'd3, W3, 1'b0);
    dut.u_array.mem_q[3] = dut.u_array.mem_q[3] ^ 11'd1;
    fetch("par_bad3", 10'd3, W3 ^ 10'd1, 1'b1);
`else
    fetch("plain3", 10'd3, W3, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
